// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round sequencer for the guessing game; drives an external LFSR,
// latches the secret, counts attempts and reports the compare result on LEDs/flags.
module guess_round_ctrl #(
   parameter int                 WIDTH      = 4,
   parameter int                 MAX_TRIES  = 5,
   parameter int                 TRY_W      = 3,
   parameter logic [4*WIDTH-1:0] SEED_TABLE = 16'h25AF,
   parameter int                 DRAW_STEPS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             get_new_num,
   input  logic             submit,
   input  logic [WIDTH-1:0] Guess,
   input  logic [WIDTH-1:0] lfsr_q,
   output logic             lfsr_load,
   output logic [WIDTH-1:0] lfsr_seed,
   output logic             lfsr_step,
   output logic             led_red,
   output logic             led_green,
   output logic             led_blue,
   output logic [TRY_W-1:0] tries_left,
   output logic             busy,
   output logic             win,
   output logic             lose
);
   localparam int CW = $clog2(DRAW_STEPS + 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEED  = 3'd1;
   localparam logic [2:0] S_DRAW  = 3'd2;
   localparam logic [2:0] S_LATCH = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_WIN   = 3'd5;
   localparam logic [2:0] S_LOSE  = 3'd6;

   // {prev, sync2, sync1}; preset high so a button held through reset makes no edge
   logic [2:0]             new_sync_q, sub_sync_q;
   logic                   new_edge, sub_edge;
   logic [2:0]             state_q, state_d;
   logic [1:0]             seed_idx_q, seed_idx_d;
   logic [WIDTH-1:0]       secret_q, secret_d;
   logic [TRY_W-1:0]       tries_q, tries_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             led_q, led_d;
   logic [4*WIDTH-1:0]     tbl_sh;

   assign new_edge = new_sync_q[1] & ~new_sync_q[2];
   assign sub_edge = sub_sync_q[1] & ~sub_sync_q[2];

   always_comb begin
      state_d    = state_q;
      seed_idx_d = seed_idx_q;
      secret_d   = secret_q;
      tries_d    = tries_q;
      cnt_d      = cnt_q;
      led_d      = led_q;
      if (new_edge) begin
         state_d = S_SEED;
         led_d   = '0;
      end else begin
         case (state_q)
            S_SEED: begin
               seed_idx_d = seed_idx_q + 2'd1;
               cnt_d      = '0;
               state_d    = S_DRAW;
            end
            S_DRAW: begin
               cnt_d   = cnt_q + CW'(1);
               state_d = (cnt_q == CW'(DRAW_STEPS - 1)) ? S_LATCH : S_DRAW;
            end
            S_LATCH: begin
               secret_d = lfsr_q;
               tries_d  = TRY_W'(MAX_TRIES);
               state_d  = S_WAIT;
            end
            S_WAIT: begin
               if (sub_edge) begin
                  led_d = {Guess > secret_q, Guess == secret_q, Guess < secret_q};
                  if (Guess == secret_q) state_d = S_WIN;
                  else begin
                     tries_d = tries_q - TRY_W'(1);
                     state_d = (tries_q == TRY_W'(1)) ? S_LOSE : S_WAIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         new_sync_q <= '1;
         sub_sync_q <= '1;
         state_q    <= S_IDLE;
         seed_idx_q <= '0;
         secret_q   <= '0;
         tries_q    <= '0;
         cnt_q      <= '0;
         led_q      <= '0;
      end else begin
         new_sync_q <= {new_sync_q[1:0], get_new_num};
         sub_sync_q <= {sub_sync_q[1:0], submit};
         state_q    <= state_d;
         seed_idx_q <= seed_idx_d;
         secret_q   <= secret_d;
         tries_q    <= tries_d;
         cnt_q      <= cnt_d;
         led_q      <= led_d;
      end
   end

   // seed index 0 lives in the MSBs of the table
   assign tbl_sh     = SEED_TABLE << (WIDTH * seed_idx_q);
   assign lfsr_load  = state_q == S_SEED;
   assign lfsr_step  = state_q == S_DRAW;
   assign lfsr_seed  = lfsr_load ? tbl_sh[4*WIDTH-1 -: WIDTH] : '0;
   assign {led_red, led_green, led_blue} = led_q;
   assign tries_left = tries_q;
   assign busy       = (state_q == S_SEED) || (state_q == S_DRAW) || (state_q == S_LATCH);
   assign win        = state_q == S_WIN;
   assign lose       = state_q == S_LOSE;
endmodule
